// File: rtl/uvmt_cv32e40s_debug_req_gen.sv
// ---------------------------------------------------------------------------
// uvmt_cv32e40s_debug_req_gen
//
// Generates a debug request towards a CV32E40S core. The generator accepts one
// command at a time. After a programmable delay it raises debug_req_o. The
// request is then held for one of two periods:
//   PULSE mode - a fixed number of cycles.
//   HALT mode  - until the core reports debug_halted_i, or until
//                TIMEOUT_CYCLES have elapsed.
//
// Parameters
//   TIMEOUT_CYCLES  Maximum number of assertion cycles in HALT mode (1..65535).
//
// Ports
//   clk_i, rst_ni    Clock, and asynchronous active-low reset.
//   cmd_valid_i      A command is offered.
//   cmd_ready_o      The generator is idle and can accept the command.
//   cmd_delay_i      Cycles from acceptance to the rise of debug_req_o.
//   cmd_mode_i       0 selects PULSE mode, 1 selects HALT mode.
//   cmd_len_i        Pulse width in PULSE mode. A value of 0 acts as 1.
//   debug_halted_i   Halt status from the core.
//   debug_req_o      Registered debug request to the core.
//   busy_o           High whenever the FSM is not in IDLE.
//   done_o           One-cycle pulse marking command completion.
//   timeout_o        One-cycle pulse, issued with done_o, on a HALT timeout.
//   req_count_o      Count of debug_req_o rising edges. Saturates.
// ---------------------------------------------------------------------------
module uvmt_cv32e40s_debug_req_gen #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [15:0] cmd_delay_i,
    input  logic        cmd_mode_i,
    input  logic [15:0] cmd_len_i,
    input  logic        debug_halted_i,
    output logic        debug_req_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        timeout_o,
    output logic [31:0] req_count_o
);

    typedef enum logic [1:0] {IDLE, DELAY, ASSERT, DONE} state_e;

    localparam logic [15:0] TIMEOUT_LD = 16'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;         // shared delay / width down-counter
    logic        mode_q, mode_d;
    logic [15:0] len_q, len_d;
    logic        debug_req_q, debug_req_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic [31:0] req_count_q, req_count_d;

    // Assertion-phase counter load, computed for both sources: the command
    // inputs (zero delay) and the latched fields (after DELAY).
    logic [15:0] width_in, width_lat;

    always_comb begin
        width_in  = cmd_mode_i ? TIMEOUT_LD : ((cmd_len_i == 16'd0) ? 16'd1 : cmd_len_i);
        width_lat = mode_q     ? TIMEOUT_LD : ((len_q     == 16'd0) ? 16'd1 : len_q);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        len_d       = len_q;
        debug_req_d = debug_req_q;
        done_d      = 1'b0;
        timeout_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    mode_d = cmd_mode_i;
                    len_d  = cmd_len_i;
                    if (cmd_delay_i == 16'd0) begin
                        state_d     = ASSERT;
                        debug_req_d = 1'b1;
                        cnt_d       = width_in;
                    end else begin
                        state_d = DELAY;
                        cnt_d   = cmd_delay_i;
                    end
                end
            end
            DELAY: begin
                // The counter is nonzero on entry, so reaching 1 ends the delay.
                // The decrement therefore never wraps.
                if (cnt_q == 16'd1) begin
                    state_d     = ASSERT;
                    debug_req_d = 1'b1;
                    cnt_d       = width_lat;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ASSERT: begin
                // The halt check comes first, so halt beats a coincident timeout.
                if (mode_q && debug_halted_i) begin
                    state_d     = DONE;
                    debug_req_d = 1'b0;
                    done_d      = 1'b1;
                end else if (cnt_q == 16'd1) begin
                    state_d     = DONE;
                    debug_req_d = 1'b0;
                    done_d      = 1'b1;
                    timeout_d   = mode_q;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        req_count_d = req_count_q;
        if (debug_req_d && !debug_req_q && (req_count_q != 32'hFFFF_FFFF)) begin
            req_count_d = req_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            mode_q      <= 1'b0;
            len_q       <= 16'd0;
            debug_req_q <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            req_count_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            len_q       <= len_d;
            debug_req_q <= debug_req_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            req_count_q <= req_count_d;
        end
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign debug_req_o = debug_req_q;
    assign done_o      = done_q;
    assign timeout_o   = timeout_q;
    assign req_count_o = req_count_q;

endmodule
